// File: rtl/writeback_unit_pkg.sv
// Shared writeback definitions: opcode encodings, link register, and the register-writing opcode list.
// Decode uses the same writes_reg() list to clear RF_VALID.
package writeback_unit_pkg;

  localparam int PC_WIDTH  = 16;
  localparam int REG_WIDTH = 16;

  localparam logic [3:0] WB_LINK_REG = 4'd7;

  localparam logic [7:0] ADD_D  = 8'h00;
  localparam logic [7:0] AND_D  = 8'h01;
  localparam logic [7:0] ADDI_D = 8'h02;
  localparam logic [7:0] ANDI_D = 8'h03;
  localparam logic [7:0] MOV    = 8'h04;
  localparam logic [7:0] MOVI_D = 8'h05;
  localparam logic [7:0] LDW    = 8'h06;
  localparam logic [7:0] STW    = 8'h07;
  localparam logic [7:0] BRN    = 8'h08;
  localparam logic [7:0] BRZ    = 8'h09;
  localparam logic [7:0] BRP    = 8'h0A;
  localparam logic [7:0] BRNZ   = 8'h0B;
  localparam logic [7:0] BRNP   = 8'h0C;
  localparam logic [7:0] BRZP   = 8'h0D;
  localparam logic [7:0] BRNZP  = 8'h0E;
  localparam logic [7:0] JMP    = 8'h10;
  localparam logic [7:0] JSR    = 8'h11;
  localparam logic [7:0] JSRR   = 8'h12;

  typedef enum logic [1:0] {SEL_ALU, SEL_MEM, SEL_PC} wb_sel_e;

  function automatic logic writes_reg(input logic [7:0] op);
    case (op)
      ADD_D, AND_D, ADDI_D, ANDI_D, MOV, MOVI_D, LDW, JSR, JSRR: writes_reg = 1'b1;
      default:                                                  writes_reg = 1'b0;
    endcase
  endfunction

  function automatic wb_sel_e data_sel(input logic [7:0] op);
    case (op)
      LDW:       data_sel = SEL_MEM;
      JSR, JSRR: data_sel = SEL_PC;
      default:   data_sel = SEL_ALU;
    endcase
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Memory-stage-in / Decode-out bundle of the writeback unit.
interface writeback_unit_if #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  parameter int PC_W   = writeback_unit_pkg::PC_WIDTH
);
  logic                         I_LOCK;
  logic [PC_W-1:0]              I_PC;
  logic [7:0]                   I_Opcode;
  logic [IDX_W-1:0]             I_DestRegIdx;
  logic [DATA_W-1:0]            I_ALUOut;
  logic [DATA_W-1:0]            I_MemOut;
  logic                         I_FetchStall;
  logic                         I_DepStall;
  logic                         I_WBAccept;
  logic                         O_WriteBackEnable;
  logic [IDX_W-1:0]             O_WriteBackRegIdx;
  logic [DATA_W-1:0]            O_WriteBackData;
  logic                         O_WBFull;
  logic [$clog2(DEPTH+1)-1:0]   O_Count;
  logic                         O_Overflow;

  modport master (
    output I_LOCK, I_PC, I_Opcode, I_DestRegIdx, I_ALUOut, I_MemOut,
           I_FetchStall, I_DepStall, I_WBAccept,
    input  O_WriteBackEnable, O_WriteBackRegIdx, O_WriteBackData,
           O_WBFull, O_Count, O_Overflow
  );

  modport slave (
    input  I_LOCK, I_PC, I_Opcode, I_DestRegIdx, I_ALUOut, I_MemOut,
           I_FetchStall, I_DepStall, I_WBAccept,
    output O_WriteBackEnable, O_WriteBackRegIdx, O_WriteBackData,
           O_WBFull, O_Count, O_Overflow
  );
endinterface

// File: rtl/writeback_unit_wb_fifo.sv
// Small in-order FIFO with registered head; state updates on the falling clock edge.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 20,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic             I_CLOCK,
  input  logic             I_RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             accepted,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A full FIFO still takes a push when the head leaves at the same edge.
  assign accepted = push & (~full | do_pop);
  assign head     = empty ? '0 : mem[rd_ptr];

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({accepted, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(negedge I_CLOCK) begin
    if (accepted) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: queues register results and holds them until Decode accepts.
// Optional retire counter output O_RetireCount is built when WB_RETIRE_CNT_EN is defined.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = REG_WIDTH,
  parameter int IDX_W  = 4
) (
  input  logic              I_CLOCK,
  input  logic              I_RESET,
  writeback_unit_if.slave   wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       O_RetireCount
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  logic              push, pop, accepted, full, empty;
  logic [IDX_W-1:0]  entry_idx;
  logic [DATA_W-1:0] entry_data;
  logic [CW-1:0]     count;
  logic [IDX_W+DATA_W-1:0] head;
  logic              overflow_q;

  always_comb begin
    push       = wb.I_LOCK & ~wb.I_FetchStall & ~wb.I_DepStall & writes_reg(wb.I_Opcode);
    entry_idx  = wb.I_DestRegIdx;
    entry_data = wb.I_ALUOut;
    case (data_sel(wb.I_Opcode))
      SEL_MEM: entry_data = wb.I_MemOut;
      SEL_PC: begin
        entry_data = wb.I_PC[DATA_W-1:0];
        entry_idx  = IDX_W'(WB_LINK_REG);
      end
      default: ;
    endcase
  end

  // Accept against an empty queue is ignored, so a fresh entry is visible for at least one cycle.
  assign pop = ~empty & wb.I_WBAccept;

  wb_fifo #(.DEPTH(DEPTH), .WIDTH(IDX_W+DATA_W)) u_fifo (
    .I_CLOCK  (I_CLOCK),
    .I_RESET  (I_RESET),
    .push     (push),
    .pop      (pop),
    .din      ({entry_idx, entry_data}),
    .accepted (accepted),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (head)
  );

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET)               overflow_q <= 1'b0;
    else if (push & ~accepted) overflow_q <= 1'b1;
  end

  assign wb.O_WriteBackEnable = ~empty;
  assign wb.O_WriteBackRegIdx = head[IDX_W+DATA_W-1:DATA_W];
  assign wb.O_WriteBackData   = head[DATA_W-1:0];
  assign wb.O_WBFull          = full;
  assign wb.O_Count           = count;
  assign wb.O_Overflow        = overflow_q;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET)  O_RetireCount <= '0;
    else if (pop) O_RetireCount <= O_RetireCount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed table-driven bench for writeback_unit (DEPTH=2), plus a pointer-wrap streaming sequence.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_unit_if #(.DEPTH(2), .DATA_W(16), .IDX_W(4)) bus();

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] rc;
  writeback_unit #(.DEPTH(2), .DATA_W(16), .IDX_W(4)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .wb(bus), .O_RetireCount(rc));
`else
  writeback_unit #(.DEPTH(2), .DATA_W(16), .IDX_W(4)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .wb(bus));
`endif

  typedef struct {
    logic        rst, lock;
    logic [7:0]  op;
    logic [3:0]  dst;
    logic [15:0] alu, mem, pc;
    logic        fs, ds, acc;
    logic        en;
    logic [3:0]  idx;
    logic [15:0] data;
    logic        full;
    logic [1:0]  cnt;
    logic        ovf;
    logic [31:0] rcnt;
  } vec_t;

  vec_t vecs [27];
  int   nvec = 0;
  int   nbad = 0;

  task automatic drive(input vec_t v);
    rst              = v.rst;
    bus.I_LOCK       = v.lock;
    bus.I_Opcode     = v.op;
    bus.I_DestRegIdx = v.dst;
    bus.I_ALUOut     = v.alu;
    bus.I_MemOut     = v.mem;
    bus.I_PC         = v.pc;
    bus.I_FetchStall = v.fs;
    bus.I_DepStall   = v.ds;
    bus.I_WBAccept   = v.acc;
  endtask

  task automatic check(input string name, input vec_t v);
    logic ok;
    ok = (bus.O_WriteBackEnable === v.en) && (bus.O_WriteBackRegIdx === v.idx) &&
         (bus.O_WriteBackData === v.data) && (bus.O_WBFull === v.full) &&
         (bus.O_Count === v.cnt) && (bus.O_Overflow === v.ovf);
`ifdef WB_RETIRE_CNT_EN
    if (rc !== v.rcnt) begin
      ok = 1'b0;
      $display("FAIL %s retire_count: got %0d want %0d", name, rc, v.rcnt);
    end
`endif
    nvec++;
    if (!ok) begin
      nbad++;
      $display("FAIL %s: got en=%0b idx=%0d data=%h full=%0b cnt=%0d ovf=%0b, want en=%0b idx=%0d data=%h full=%0b cnt=%0d ovf=%0b",
               name, bus.O_WriteBackEnable, bus.O_WriteBackRegIdx, bus.O_WriteBackData,
               bus.O_WBFull, bus.O_Count, bus.O_Overflow,
               v.en, v.idx, v.data, v.full, v.cnt, v.ovf);
    end
  endtask

  // Apply at mid-low phase, let the falling edge update state, then sample 2 time units later.
  task automatic step(input string name, input vec_t v);
    drive(v);
    @(negedge clk);
    #2;
    check(name, v);
  endtask

  initial begin
    vec_t v;
    int   exp_rc;

    //           rst   lock  op      dst    alu       mem       pc        fs    ds    acc    en    idx    data      full  cnt   ovf   rc
    vecs[0]  = '{1'b1,1'b1,ADDI_D,4'd3,16'h0005,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b0,32'd0};
    vecs[1]  = '{1'b1,1'b1,ADDI_D,4'd3,16'h0005,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b0,32'd0};
    vecs[2]  = '{1'b0,1'b1,ADDI_D,4'd3,16'h0005,16'h0000,16'h0000,1'b0,1'b0,1'b1, 1'b1,4'd3,16'h0005,1'b0,2'd1,1'b0,32'd0};
    vecs[3]  = '{1'b0,1'b0,ADDI_D,4'd3,16'h0005,16'h0000,16'h0000,1'b0,1'b0,1'b1, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b0,32'd1};
    vecs[4]  = '{1'b0,1'b1,LDW,   4'd2,16'h0010,16'hBEEF,16'h0000,1'b0,1'b0,1'b0, 1'b1,4'd2,16'hBEEF,1'b0,2'd1,1'b0,32'd1};
    vecs[5]  = '{1'b0,1'b1,JSR,   4'd5,16'h1234,16'h0000,16'h0040,1'b0,1'b0,1'b1, 1'b1,4'd7,16'h0040,1'b0,2'd1,1'b0,32'd2};
    vecs[6]  = '{1'b0,1'b0,JSR,   4'd5,16'h1234,16'h0000,16'h0040,1'b0,1'b0,1'b1, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b0,32'd3};
    vecs[7]  = '{1'b0,1'b1,ADDI_D,4'd1,16'h1111,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b1,4'd1,16'h1111,1'b0,2'd1,1'b0,32'd3};
    vecs[8]  = '{1'b0,1'b1,ADDI_D,4'd2,16'h2222,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b1,4'd1,16'h1111,1'b1,2'd2,1'b0,32'd3};
    vecs[9]  = '{1'b0,1'b1,ADDI_D,4'd3,16'h3333,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b1,4'd1,16'h1111,1'b1,2'd2,1'b1,32'd3};
    vecs[10] = '{1'b0,1'b0,ADDI_D,4'd3,16'h3333,16'h0000,16'h0000,1'b0,1'b0,1'b1, 1'b1,4'd2,16'h2222,1'b0,2'd1,1'b1,32'd4};
    vecs[11] = '{1'b0,1'b0,ADDI_D,4'd3,16'h3333,16'h0000,16'h0000,1'b0,1'b0,1'b1, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b1,32'd5};
    vecs[12] = '{1'b0,1'b1,AND_D, 4'd1,16'h1111,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b1,4'd1,16'h1111,1'b0,2'd1,1'b1,32'd5};
    vecs[13] = '{1'b0,1'b1,ANDI_D,4'd2,16'h2222,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b1,4'd1,16'h1111,1'b1,2'd2,1'b1,32'd5};
    vecs[14] = '{1'b0,1'b1,MOVI_D,4'd4,16'h4444,16'h0000,16'h0000,1'b0,1'b0,1'b1, 1'b1,4'd2,16'h2222,1'b1,2'd2,1'b1,32'd6};
    vecs[15] = '{1'b0,1'b0,MOVI_D,4'd4,16'h4444,16'h0000,16'h0000,1'b0,1'b0,1'b1, 1'b1,4'd4,16'h4444,1'b0,2'd1,1'b1,32'd7};
    vecs[16] = '{1'b0,1'b0,MOVI_D,4'd4,16'h4444,16'h0000,16'h0000,1'b0,1'b0,1'b1, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b1,32'd8};
    vecs[17] = '{1'b0,1'b1,STW,   4'd6,16'h0009,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b1,32'd8};
    vecs[18] = '{1'b0,1'b1,BRZ,   4'd6,16'h0009,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b1,32'd8};
    vecs[19] = '{1'b0,1'b1,ADD_D, 4'd5,16'h0009,16'h0000,16'h0000,1'b0,1'b1,1'b0, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b1,32'd8};
    vecs[20] = '{1'b0,1'b1,ADD_D, 4'd5,16'h0009,16'h0000,16'h0000,1'b1,1'b0,1'b0, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b1,32'd8};
    vecs[21] = '{1'b0,1'b1,JMP,   4'd5,16'h0009,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b1,32'd8};
    vecs[22] = '{1'b0,1'b1,MOV,   4'd8,16'hABCD,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b1,4'd8,16'hABCD,1'b0,2'd1,1'b1,32'd8};
    vecs[23] = '{1'b1,1'b1,MOV,   4'd9,16'h5A5A,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b0,32'd0};
    vecs[24] = '{1'b0,1'b0,MOV,   4'd9,16'h5A5A,16'h0000,16'h0000,1'b0,1'b0,1'b1, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b0,32'd0};
    vecs[25] = '{1'b0,1'b1,JSRR,  4'd2,16'h0077,16'h0000,16'h1234,1'b0,1'b0,1'b0, 1'b1,4'd7,16'h1234,1'b0,2'd1,1'b0,32'd0};
    vecs[26] = '{1'b0,1'b0,JSRR,  4'd2,16'h0077,16'h0000,16'h1234,1'b0,1'b0,1'b1, 1'b0,4'd0,16'h0000,1'b0,2'd0,1'b0,32'd1};

    drive(vecs[0]);
    for (int i = 0; i < 27; i++) step($sformatf("vec%0d", i), vecs[i]);

    // Streaming at occupancy 1: each edge pops the head and pushes a new one, walking the pointers round.
    exp_rc = 1;
    v = vecs[26];
    v.lock = 1'b1; v.op = ADDI_D; v.dst = 4'd1; v.alu = 16'h1000; v.acc = 1'b0;
    v.en = 1'b1; v.idx = 4'd1; v.data = 16'h1000; v.full = 1'b0; v.cnt = 2'd1; v.ovf = 1'b0; v.rcnt = 32'(exp_rc);
    step("wrap_fill", v);
    for (int i = 0; i < 6; i++) begin
      exp_rc++;
      v.op = ADD_D; v.dst = 4'(i + 2); v.alu = 16'h2000 + 16'(i); v.acc = 1'b1;
      v.idx = 4'(i + 2); v.data = 16'h2000 + 16'(i); v.rcnt = 32'(exp_rc);
      step($sformatf("wrap%0d", i), v);
    end
    exp_rc++;
    v.lock = 1'b0; v.en = 1'b0; v.idx = 4'd0; v.data = 16'h0000; v.cnt = 2'd0; v.rcnt = 32'(exp_rc);
    step("wrap_drain", v);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
